stopwatch_btn_ctrl: RTL and testbench
=====================================

Name: stopwatch_btn_ctrl

Overview:
Upstream control stage for the stopwatch datapath. It synchronises and debounces two raw push-buttons (start/stop, lap/clear) and runs a small mode FSM. It emits the run-enable level that gates the stopwatch clock divider, a lap-hold level that freezes the display, and a one-cycle clear pulse for the counters. Runs on the 50 MHz board clock.

Parameters:
DEB_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); must be >= 2.
LONG_CYCLES, 100000000, cycles the debounced lap button must stay high to count as a long press (2 s); used only with LONGPRESS_CLR_EN.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-low reset
btn_start  input  1  raw start/stop button, active-high, asynchronous to clk
btn_lap  input  1  raw lap/clear button, active-high, asynchronous to clk
start_stop  output  1  1 = counting enabled; drives the clock-divider enable
lap_hold  output  1  1 = display frozen at lap value; counting unaffected
clr  output  1  one-cycle pulse; zeroes all stopwatch counters
state  output  2  current FSM state: 0 IDLE, 1 RUN, 2 LAP, 3 PAUSE

Behaviour:
- Reset (rst=0, asynchronous): all flops cleared. Outputs: start_stop=0, lap_hold=0, clr=0, state=IDLE. Sync flops, debounced levels and counters all read 0.
- Reset has priority over everything, including mid-debounce and mid-long-press; no pulse may be emitted on reset release.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - A counter increments while the synchronised value differs from the debounced level.
  - The counter clears to 0 on any cycle where they match.
  - When the counter reaches DEB_CYCLES, the debounced level toggles and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles produces no change.
- Edge detect: the press event is the 0->1 transition of the debounced level, one cycle wide. Release events are ignored.
- Latency: a stable press first sampled at edge 1 updates the FSM-registered outputs at edge DEB_CYCLES+3.
- FSM transitions (S = start press, L = lap press):
  - IDLE: S -> RUN. L -> stay in IDLE and emit clr.
  - RUN: S -> PAUSE. L -> LAP.
  - LAP: S -> PAUSE and release hold. L -> RUN and release hold.
  - PAUSE: S -> RUN. L -> IDLE and emit clr.
- Registered outputs:
  - start_stop = 1 in RUN and LAP.
  - lap_hold = 1 in LAP only.
  - clr is a one-cycle registered pulse, asserted in the same cycle the state update lands.
- Simultaneous S and L in the same cycle: S takes priority and L is discarded. The lap event is not queued.
- Holding a button produces exactly one event. A new event requires release, debounced low, then a new press.

Optional Feature:
LONGPRESS_CLR_EN
- Defined:
  - A LONG_CYCLES-wide counter runs while the debounced lap level is 1 and clears when it is 0.
  - When the counter reaches LONG_CYCLES, the FSM goes to IDLE from any state, emits clr once, and forces start_stop=0 and lap_hold=0.
  - Further long-press action is suppressed until the button is released.
  - The short press that started the hold is still processed normally on its press edge.
- Undefined: no long-press logic is synthesised. Clearing happens only via L in IDLE or PAUSE.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20):
- Reset check: rst=0 for 3 cycles, then release with both buttons low -> start_stop=0, lap_hold=0, clr=0, state=0 for 50 cycles.
- Start latency: btn_start held high from edge 1 -> start_stop=1 and state=1 exactly at edge 7, not before; holding 100 cycles gives no further change.
- Glitch rejection: btn_start high for 3 cycles, then low -> no state change. Bounce pattern 1,0,1,1,0 followed by a stable high -> exactly one RUN transition.
- Full sequence: S, L, L, S, L (each press held 10 cycles, then released 10 cycles) -> state 1,2,1,3,0. lap_hold=1 only in state 2. clr high for exactly one cycle at the final transition.
- Simultaneous presses: in RUN, btn_start and btn_lap rise on the same edge -> state=3 (PAUSE), lap_hold=0, no clr.
- Long-press clear (macro defined): in RUN, hold btn_lap for 40 cycles -> LAP on the press edge, then IDLE with a single clr pulse 20 cycles after the debounced level rises; with the macro undefined -> remains in LAP with no clr.

Source files
------------

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button front end: 2-flop sync, debounce, press detect and mode FSM.
// Define LONGPRESS_CLR_EN to add the long-press-on-lap clear to IDLE.
module stopwatch_btn_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned LONG_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       start_stop,
  output logic       lap_hold,
  output logic       clr,
  output logic [1:0] state
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StLap   = 2'd2,
    StPause = 2'd3
  } state_e;

  // Bit 0 is the start/stop button, bit 1 the lap/clear button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d, deb_prev_q;
  logic [DebW-1:0] cnt_q [2];
  logic [DebW-1:0] cnt_d [2];
  logic [1:0]      press;
  logic            long_fire;

  state_e state_q, state_d;
  logic   clr_q, clr_d;
  logic   start_stop_q, start_stop_d;
  logic   lap_hold_q, lap_hold_d;

  assign btn_raw = {btn_lap, btn_start};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

`ifdef LONGPRESS_CLR_EN
  localparam int unsigned LongW = $clog2(LONG_CYCLES + 1);
  logic [LongW-1:0] long_cnt_q;

  // Saturates at LONG_CYCLES so a held button fires once until released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      long_cnt_q <= '0;
    end else if (!deb_q[1]) begin
      long_cnt_q <= '0;
    end else if (long_cnt_q != LongW'(LONG_CYCLES)) begin
      long_cnt_q <= long_cnt_q + LongW'(1);
    end
  end

  assign long_fire = deb_q[1] && (long_cnt_q == LongW'(LONG_CYCLES - 1));
`else
  // Parameter kept visible so both builds share one interface.
  assign long_fire = 1'b0 & (LONG_CYCLES == 0);
`endif

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    // Start has priority; a simultaneous lap press is dropped.
    unique case (state_q)
      StIdle: begin
        if (press[0]) begin
          state_d = StRun;
        end else if (press[1]) begin
          clr_d = 1'b1;
        end
      end
      StRun: begin
        if (press[0]) begin
          state_d = StPause;
        end else if (press[1]) begin
          state_d = StLap;
        end
      end
      StLap: begin
        if (press[0]) begin
          state_d = StPause;
        end else if (press[1]) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (press[0]) begin
          state_d = StRun;
        end else if (press[1]) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end
      end
    endcase
    if (long_fire) begin
      state_d = StIdle;
      clr_d   = 1'b1;
    end
    start_stop_d = (state_d == StRun) || (state_d == StLap);
    lap_hold_d   = (state_d == StLap);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      clr_q        <= 1'b0;
      start_stop_q <= 1'b0;
      lap_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      start_stop_q <= start_stop_d;
      lap_hold_q   <= lap_hold_d;
    end
  end

  assign start_stop = start_stop_q;
  assign lap_hold   = lap_hold_q;
  assign clr        = clr_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Directed self-checking bench for stopwatch_btn_ctrl (DEB_CYCLES=4, LONG_CYCLES=20).
module tb_stopwatch_btn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       start_stop, lap_hold, clr;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  stopwatch_btn_ctrl #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .start_stop(start_stop),
    .lap_hold  (lap_hold),
    .clr       (clr),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Packs {start_stop, lap_hold, clr, state} as the DUT should show them in state st.
  function automatic logic [31:0] exp_outs(input int st, input logic c);
    logic ss, lh;
    ss = (st == 1) || (st == 2);
    lh = (st == 2);
    return {27'd0, ss, lh, c, 2'(st)};
  endfunction

  function automatic logic [31:0] outs();
    return {27'd0, start_stop, lap_hold, clr, state};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the given buttons 10 cycles, release 10 cycles; return clr pulse count.
  task automatic press(input logic s, input logic l, output int pulses);
    pulses = 0;
    btn_start = s;
    btn_lap   = l;
    repeat (10) begin
      step();
      if (clr) pulses++;
    end
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    repeat (10) begin
      step();
      if (clr) pulses++;
    end
  endtask

  int seq_s   [5] = '{1, 0, 0, 1, 0};
  int seq_st  [5] = '{1, 2, 1, 3, 0};
  int seq_clr [5] = '{0, 0, 0, 0, 1};
  int bounce  [5] = '{1, 0, 1, 1, 0};

  initial begin
    int p;
    int exp_st;
    logic exp_c;

    // Reset and idle hold
    repeat (3) step();
    check_eq("reset_asserted", outs(), exp_outs(0, 1'b0));
    rst = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      check_eq("reset_idle", outs(), exp_outs(0, 1'b0));
    end

    // Start latency: press seen at edge 1, outputs land at edge 7
    btn_start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_eq($sformatf("start_lat_e%0d", k), outs(), exp_outs((k >= 7) ? 1 : 0, 1'b0));
    end
    for (int k = 0; k < 100; k++) begin
      step();
      if (k % 10 == 9) check_eq("start_hold", outs(), exp_outs(1, 1'b0));
    end
    btn_start = 1'b0;
    repeat (10) step();
    check_eq("start_release", outs(), exp_outs(1, 1'b0));

    // Glitch of 3 cycles is rejected
    btn_start = 1'b1;
    repeat (3) step();
    btn_start = 1'b0;
    repeat (15) step();
    check_eq("glitch_reject", outs(), exp_outs(1, 1'b0));

    // Bounce then stable high: exactly one transition RUN -> PAUSE
    for (int k = 0; k < 5; k++) begin
      btn_start = bounce[k][0];
      step();
    end
    btn_start = 1'b1;
    repeat (15) step();
    check_eq("bounce_press", outs(), exp_outs(3, 1'b0));
    btn_start = 1'b0;
    repeat (15) step();
    check_eq("bounce_release", outs(), exp_outs(3, 1'b0));

    // Reset mid-debounce: no event escapes on release
    btn_start = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    check_eq("reset_async", outs(), exp_outs(0, 1'b0));
    step();
    btn_start = 1'b0;
    rst = 1'b1;
    p = 0;
    repeat (20) begin
      step();
      if (clr) p++;
    end
    check_eq("reset_mid_state", outs(), exp_outs(0, 1'b0));
    check_eq("reset_mid_clr", p, 0);

    // Full sequence S, L, L, S, L
    for (int k = 0; k < 5; k++) begin
      press(seq_s[k][0], ~seq_s[k][0], p);
      check_eq($sformatf("seq%0d_outs", k), outs(), exp_outs(seq_st[k], 1'b0));
      check_eq($sformatf("seq%0d_clr", k), p, seq_clr[k]);
    end

    // Simultaneous press in RUN: start wins
    press(1'b1, 1'b0, p);
    check_eq("simul_pre", outs(), exp_outs(1, 1'b0));
    press(1'b1, 1'b1, p);
    check_eq("simul_outs", outs(), exp_outs(3, 1'b0));
    check_eq("simul_clr", p, 0);

    // Long lap hold from RUN
    press(1'b1, 1'b0, p);
    check_eq("long_pre", outs(), exp_outs(1, 1'b0));
    btn_lap = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
`ifdef LONGPRESS_CLR_EN
      exp_st = (k < 7) ? 1 : ((k < 26) ? 2 : 0);
      exp_c  = (k == 26);
`else
      exp_st = (k < 7) ? 1 : 2;
      exp_c  = 1'b0;
`endif
      check_eq($sformatf("long_e%0d", k), outs(), exp_outs(exp_st, exp_c));
    end
    btn_lap = 1'b0;
    p = 0;
    repeat (15) begin
      step();
      if (clr) p++;
    end
`ifdef LONGPRESS_CLR_EN
    check_eq("long_after", outs(), exp_outs(0, 1'b0));
`else
    check_eq("long_after", outs(), exp_outs(2, 1'b0));
`endif
    check_eq("long_after_clr", p, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
